// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: drives the instruction memory request, keeps the
// architectural PC and the IF/ID pipeline register, and handles stalls and
// taken-branch redirects.
//   clk, reset         : rising-edge clock, asynchronous active-high reset
//   stall              : hold PC and IF/ID contents
//   branch_taken       : one-cycle redirect to branch_target (word aligned)
//   imem_req/imem_addr : memory request and its word address
//   imem_ready/rdata   : memory response for the current request
//   if_id_*            : IF/ID register (valid, instruction, pc)
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] hold_buf_q, hold_buf_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;

  logic [31:0] next_addr;
  logic [31:0] target_aligned;

  assign next_addr      = req_addr_q + 32'd4;  // wraps modulo 2^32
  assign target_aligned = {branch_target[31:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      req_addr_q    <= RESET_PC;
      hold_buf_q    <= '0;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc_q    <= RESET_PC;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      hold_buf_q    <= hold_buf_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    hold_buf_d    = hold_buf_q;
    if_id_valid_d = if_id_valid_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;

    if (branch_taken) begin
      // Redirect beats stall. An unanswered request cannot be cancelled, so
      // its response is swallowed in DISCARD before fetching from pc_q.
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
      pc_d          = target_aligned;
      unique case (state_q)
        FETCH: begin
          if (imem_ready) begin
            req_addr_d = target_aligned;
            state_d    = FETCH;
          end else begin
            state_d = DISCARD;
          end
        end
        HOLD: begin
          req_addr_d = target_aligned;
          state_d    = FETCH;
        end
        DISCARD: state_d = DISCARD;
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ready) begin
            if (stall) begin
              hold_buf_d = imem_rdata;
              state_d    = HOLD;
            end else begin
              if_id_valid_d = 1'b1;
              if_id_instr_d = imem_rdata;
              if_id_pc_d    = req_addr_q;
              pc_d          = next_addr;
              req_addr_d    = next_addr;
            end
          end else if (!stall) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
          end
        end
        HOLD: begin
          if (!stall) begin
            if_id_valid_d = 1'b1;
            if_id_instr_d = hold_buf_q;
            if_id_pc_d    = req_addr_q;
            pc_d          = next_addr;
            req_addr_d    = next_addr;
            state_d       = FETCH;
          end
        end
        DISCARD: begin
          if (imem_ready) begin
            req_addr_d = pc_q;
            state_d    = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign imem_req          = (state_q != HOLD);
  assign imem_addr         = req_addr_q;
  assign if_id_valid       = if_id_valid_q;
  assign if_id_instruction = if_id_instr_q;
  assign if_id_pc          = if_id_pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
    .if_id_valid      (if_id_valid),
    .if_id_instruction(if_id_instruction),
    .if_id_pc         (if_id_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h00A0_0093;
      32'h0000_0004: mem_word = 32'h0020_2183;
      32'h0000_0008: mem_word = 32'h0030_8213;
      32'h0000_000C: mem_word = 32'h0000_A303;
      32'h0000_0020: mem_word = 32'hBAD0_0000;
      32'h0000_0040: mem_word = 32'h00C0_0513;
      32'hFFFF_FFFC: mem_word = 32'hFE00_0EE3;
      default:       mem_word = {a[11:0], 20'h00093};
    endcase
  endfunction

  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every newly presented valid IF/ID entry is popped and compared.
  logic        prev_valid = 1'b0;
  logic [31:0] prev_instr = '0;
  logic [31:0] prev_pc    = '0;

  always @(negedge clk) begin
    if (if_id_valid === 1'b1 &&
        (!prev_valid || if_id_instruction !== prev_instr || if_id_pc !== prev_pc)) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ifid: got %08h/%08h expected none", if_id_instruction, if_id_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ifid_instr", if_id_instruction, e.instr);
        chk("ifid_pc", if_id_pc, e.pc);
      end
    end
    prev_valid = (if_id_valid === 1'b1);
    prev_instr = if_id_instruction;
    prev_pc    = if_id_pc;
  end

  initial begin
    #1 reset = 1'b1;
    #3;
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_instr", if_id_instruction, NOP);
    chk("rst_pc", if_id_pc, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h0);

    tick;
    reset      = 1'b0;
    imem_ready = 1'b1;
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
    push(32'h00A0_0093, 32'h0);
    tick;
    chk("seq_addr4", imem_addr, 32'h4);
    push(32'h0020_2183, 32'h4);
    tick;
    chk("seq_addr8", imem_addr, 32'h8);

    // Two wait cycles at address 8
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("wait_addr", imem_addr, 32'h8);
      chk("wait_valid", {31'd0, if_id_valid}, 32'd0);
      chk("wait_instr", if_id_instruction, NOP);
    end
    imem_ready = 1'b1;
    push(32'h0030_8213, 32'h8);
    tick;
    chk("addr12", imem_addr, 32'hC);

    // Stall on the response for address 12
    stall = 1'b1;
    tick;
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_pc", if_id_pc, 32'h8);
    tick;
    chk("hold_req2", {31'd0, imem_req}, 32'd0);
    chk("hold_instr", if_id_instruction, 32'h0030_8213);
    chk("hold_valid", {31'd0, if_id_valid}, 32'd1);
    stall = 1'b0;
    push(32'h0000_A303, 32'hC);
    tick;
    chk("release_req", {31'd0, imem_req}, 32'd1);
    chk("release_addr", imem_addr, 32'h10);

    push(32'h0100_0093, 32'h10);
    push(32'h0140_0093, 32'h14);
    push(32'h0180_0093, 32'h18);
    push(32'h01C0_0093, 32'h1C);
    for (int i = 0; i < 4; i++) tick;
    chk("addr20", imem_addr, 32'h20);

    // Branch while the request to 0x20 is outstanding
    imem_ready = 1'b0;
    tick;
    chk("bubble_valid", {31'd0, if_id_valid}, 32'd0);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0043;
    tick;
    branch_taken = 1'b0;
    chk("discard_req", {31'd0, imem_req}, 32'd1);
    chk("discard_addr", imem_addr, 32'h20);
    chk("discard_valid", {31'd0, if_id_valid}, 32'd0);
    imem_ready = 1'b1;
    tick;
    chk("redirect_addr", imem_addr, 32'h40);
    chk("dropped_valid", {31'd0, if_id_valid}, 32'd0);
    push(32'h00C0_0513, 32'h40);
    tick;
    chk("addr44", imem_addr, 32'h44);

    // Branch and stall together: the branch wins
    branch_taken  = 1'b1;
    stall         = 1'b1;
    branch_target = 32'hFFFF_FFFE;
    tick;
    branch_taken = 1'b0;
    stall        = 1'b0;
    chk("flush_valid", {31'd0, if_id_valid}, 32'd0);
    chk("flush_instr", if_id_instruction, NOP);
    chk("flush_addr", imem_addr, 32'hFFFF_FFFC);
    push(32'hFE00_0EE3, 32'hFFFF_FFFC);
    tick;
    chk("wrap_addr", imem_addr, 32'h0);

    // Enter HOLD, then reset asynchronously mid-cycle
    stall = 1'b1;
    tick;
    chk("hold2_req", {31'd0, imem_req}, 32'd0);
    chk("hold2_pc", if_id_pc, 32'hFFFF_FFFC);
    #3 reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("arst_instr", if_id_instruction, NOP);
    chk("arst_pc", if_id_pc, 32'h0);
    chk("arst_req", {31'd0, imem_req}, 32'd1);
    chk("arst_addr", imem_addr, 32'h0);
    stall = 1'b0;
    tick;
    reset      = 1'b0;
    imem_ready = 1'b1;
    push(32'h00A0_0093, 32'h0);
    tick;
    chk("restart_addr", imem_addr, 32'h4);
    imem_ready = 1'b0;
    tick;
    tick;
    chk("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
